hr_window_ctrl: RTL and testbench



---
 rtl/hr_window_if.sv | 34 +++
 rtl/hr_window_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_hr_window_ctrl.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hr_window_if.sv
// Bundle of control, configuration and result signals for hr_window_ctrl.
// Signal prefixes are from the controller's point of view: i_ = into it, o_ = out of it.
interface hr_window_if #(
  parameter int CNT_W = 8
) ();
  logic             i_start;
  logic             i_stop;
  logic             i_cls;
  logic             i_cont_mode;
  logic             i_pulse;
  logic             i_sec_tick;
  logic [CNT_W-1:0] i_thr_hi;
  logic [CNT_W-1:0] i_thr_lo;
  logic [CNT_W-1:0] o_count;
  logic [CNT_W-1:0] o_rate;
  logic             o_rate_valid;
  logic             o_alarm_hi;
  logic             o_alarm_lo;
  logic             o_overflow;
  logic             o_busy;
  logic [1:0]       o_state;

  // Driver side: pulse front end, tick generator and control logic.
  modport master (
    output i_start, i_stop, i_cls, i_cont_mode, i_pulse, i_sec_tick, i_thr_hi, i_thr_lo,
    input  o_count, o_rate, o_rate_valid, o_alarm_hi, o_alarm_lo, o_overflow, o_busy, o_state
  );

  // Controller side.
  modport slave (
    input  i_start, i_stop, i_cls, i_cont_mode, i_pulse, i_sec_tick, i_thr_hi, i_thr_lo,
    output o_count, o_rate, o_rate_valid, o_alarm_hi, o_alarm_lo, o_overflow, o_busy, o_state
  );
endinterface

// File: rtl/hr_window_ctrl.sv
// Heart-rate window controller: counts pulse rising edges over a window of
// second ticks, captures the rate, raises high/low alarms, and runs either
// single-shot (wait for cls) or in back-to-back windows.
module hr_window_ctrl #(
  parameter int CNT_W        = 8,
  parameter int WINDOW_TICKS = 60,
  parameter int HOLD_CYCLES  = 2
) (
  input  logic         clk,
  input  logic         rst,
  hr_window_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_COUNT    = 2'd1,
    S_HOLD     = 2'd2,
    S_WAIT_CLS = 2'd3
  } state_t;

  localparam int TICK_W = (WINDOW_TICKS > 1) ? $clog2(WINDOW_TICKS) : 1;
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(WINDOW_TICKS - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_count, w_count_nxt;
  logic [TICK_W-1:0] r_tick, w_tick_nxt;
  logic [HOLD_W-1:0] r_hold, w_hold_nxt;
  logic [CNT_W-1:0]  r_rate, w_rate_nxt;
  logic              r_rate_valid, w_rate_valid_nxt;
  logic              r_alarm_hi, w_alarm_hi_nxt;
  logic              r_alarm_lo, w_alarm_lo_nxt;
  logic              r_overflow, w_overflow_nxt;
  logic              r_busy;
  logic              r_pulse_d;

  logic              w_edge;
  logic              w_cnt_sat;
  logic [CNT_W-1:0]  w_count_inc;
  logic              w_win_end;
  logic              w_over_hi;

  assign w_edge      = bus.i_pulse & ~r_pulse_d;
  assign w_cnt_sat   = (r_count == CNT_MAX);
  // Saturating count including an edge seen this cycle; also the final count at window end.
  assign w_count_inc = (w_edge && !w_cnt_sat) ? (r_count + CNT_W'(1)) : r_count;
  assign w_win_end   = bus.i_sec_tick && (r_tick == TICK_LAST);
  // Compare the registered count so the alarm follows one cycle after the crossing.
  assign w_over_hi   = (r_count > bus.i_thr_hi);

  // Next-state and next-datapath values; stop beats every other transition outside IDLE.
  always_comb begin
    w_state_nxt      = r_state;
    w_count_nxt      = r_count;
    w_tick_nxt       = r_tick;
    w_hold_nxt       = r_hold;
    w_rate_nxt       = r_rate;
    w_rate_valid_nxt = 1'b0;
    w_alarm_hi_nxt   = r_alarm_hi;
    w_alarm_lo_nxt   = r_alarm_lo;
    w_overflow_nxt   = r_overflow;

    case (r_state)
      S_IDLE: begin
        w_count_nxt    = '0;
        w_tick_nxt     = '0;
        w_hold_nxt     = '0;
        w_alarm_hi_nxt = 1'b0;
        w_alarm_lo_nxt = 1'b0;
        w_overflow_nxt = 1'b0;
        if (bus.i_start) begin
          w_state_nxt = S_COUNT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end

      S_COUNT: begin
        if (bus.i_stop) begin
          w_state_nxt    = S_IDLE;
          w_count_nxt    = '0;
          w_tick_nxt     = '0;
          w_hold_nxt     = '0;
          w_alarm_hi_nxt = 1'b0;
          w_alarm_lo_nxt = 1'b0;
          w_overflow_nxt = 1'b0;
        end else begin
          w_count_nxt    = w_count_inc;
          w_overflow_nxt = r_overflow | (w_edge & w_cnt_sat);
          w_alarm_hi_nxt = r_alarm_hi | w_over_hi;
          if (w_win_end) begin
            w_rate_nxt       = w_count_inc;
            w_alarm_lo_nxt   = (w_count_inc < bus.i_thr_lo);
            w_rate_valid_nxt = 1'b1;
            w_tick_nxt       = '0;
            w_hold_nxt       = '0;
            w_state_nxt      = S_HOLD;
          end else if (bus.i_sec_tick) begin
            w_tick_nxt = r_tick + TICK_W'(1);
          end else begin
            w_tick_nxt = r_tick;
          end
        end
      end

      S_HOLD: begin
        if (bus.i_stop) begin
          w_state_nxt    = S_IDLE;
          w_count_nxt    = '0;
          w_tick_nxt     = '0;
          w_hold_nxt     = '0;
          w_alarm_hi_nxt = 1'b0;
          w_alarm_lo_nxt = 1'b0;
          w_overflow_nxt = 1'b0;
        end else begin
          // Count is frozen here, but a crossing on the window-end edge still latches.
          w_alarm_hi_nxt = r_alarm_hi | w_over_hi;
          if (r_hold == HOLD_LAST) begin
            w_hold_nxt = '0;
            if (bus.i_cont_mode) begin
              // alarm_lo deliberately survives until the next window end.
              w_state_nxt    = S_COUNT;
              w_count_nxt    = '0;
              w_tick_nxt     = '0;
              w_overflow_nxt = 1'b0;
              w_alarm_hi_nxt = 1'b0;
            end else begin
              w_state_nxt = S_WAIT_CLS;
            end
          end else begin
            w_hold_nxt = r_hold + HOLD_W'(1);
          end
        end
      end

      S_WAIT_CLS: begin
        if (bus.i_stop || bus.i_cls) begin
          w_state_nxt    = S_IDLE;
          w_count_nxt    = '0;
          w_tick_nxt     = '0;
          w_hold_nxt     = '0;
          w_alarm_hi_nxt = 1'b0;
          w_alarm_lo_nxt = 1'b0;
          w_overflow_nxt = 1'b0;
        end else begin
          w_state_nxt = S_WAIT_CLS;
        end
      end

      default: begin
        w_state_nxt    = S_IDLE;
        w_count_nxt    = '0;
        w_tick_nxt     = '0;
        w_hold_nxt     = '0;
        w_alarm_hi_nxt = 1'b0;
        w_alarm_lo_nxt = 1'b0;
        w_overflow_nxt = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath and output registers, plus the always-running pulse delay for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count      <= '0;
      r_tick       <= '0;
      r_hold       <= '0;
      r_rate       <= '0;
      r_rate_valid <= 1'b0;
      r_alarm_hi   <= 1'b0;
      r_alarm_lo   <= 1'b0;
      r_overflow   <= 1'b0;
      r_busy       <= 1'b0;
      r_pulse_d    <= 1'b0;
    end else begin
      r_count      <= w_count_nxt;
      r_tick       <= w_tick_nxt;
      r_hold       <= w_hold_nxt;
      r_rate       <= w_rate_nxt;
      r_rate_valid <= w_rate_valid_nxt;
      r_alarm_hi   <= w_alarm_hi_nxt;
      r_alarm_lo   <= w_alarm_lo_nxt;
      r_overflow   <= w_overflow_nxt;
      r_busy       <= (w_state_nxt != S_IDLE);
      r_pulse_d    <= bus.i_pulse;
    end
  end

  assign bus.o_count      = r_count;
  assign bus.o_rate       = r_rate;
  assign bus.o_rate_valid = r_rate_valid;
  assign bus.o_alarm_hi   = r_alarm_hi;
  assign bus.o_alarm_lo   = r_alarm_lo;
  assign bus.o_overflow   = r_overflow;
  assign bus.o_busy       = r_busy;
  assign bus.o_state      = r_state;

endmodule

// File: tb/tb_hr_window_ctrl.sv
// Directed bench for hr_window_ctrl with CNT_W=4, WINDOW_TICKS=4, HOLD_CYCLES=2,
// thr_hi=5, thr_lo=2. Inputs change and outputs are sampled 1 time unit after posedge.
module tb_hr_window_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  hr_window_if #(.CNT_W(4)) bus ();

  hr_window_ctrl #(
    .CNT_W        (4),
    .WINDOW_TICKS (4),
    .HOLD_CYCLES  (2)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One rising edge on pulse, then a low cycle so the next one is distinct.
  task automatic edge_pulse();
    bus.i_pulse = 1'b1;
    cyc();
    bus.i_pulse = 1'b0;
    cyc();
  endtask

  // One sec_tick strobe without a trailing gap.
  task automatic sec();
    bus.i_sec_tick = 1'b1;
    cyc();
    bus.i_sec_tick = 1'b0;
  endtask

  task automatic sec_gap();
    sec();
    cyc();
  endtask

  task automatic start_window();
    bus.i_start = 1'b1;
    cyc();
    bus.i_start = 1'b0;
  endtask

  task automatic release_cls();
    bus.i_cls = 1'b1;
    cyc();
    bus.i_cls = 1'b0;
  endtask

  initial begin
    rst             = 1'b1;
    bus.i_start     = 1'b0;
    bus.i_stop      = 1'b0;
    bus.i_cls       = 1'b0;
    bus.i_cont_mode = 1'b0;
    bus.i_pulse     = 1'b0;
    bus.i_sec_tick  = 1'b0;
    bus.i_thr_hi    = 4'd5;
    bus.i_thr_lo    = 4'd2;
    repeat (3) cyc();
    rst = 1'b0;
    cyc();
    chk("rst_state", 32'(bus.o_state), 32'd0);
    chk("rst_count", 32'(bus.o_count), 32'd0);
    chk("rst_rate",  32'(bus.o_rate),  32'd0);
    chk("rst_busy",  32'(bus.o_busy),  32'd0);
    chk("rst_flags", 32'({bus.o_rate_valid, bus.o_alarm_hi, bus.o_alarm_lo, bus.o_overflow}), 32'd0);

    // Single-shot: 3 edges, 4 ticks.
    start_window();
    chk("ss_state_count", 32'(bus.o_state), 32'd1);
    chk("ss_busy", 32'(bus.o_busy), 32'd1);
    repeat (3) edge_pulse();
    chk("ss_count3", 32'(bus.o_count), 32'd3);
    repeat (3) sec_gap();
    chk("ss_no_rv_early", 32'(bus.o_rate_valid), 32'd0);
    sec();
    chk("ss_state_hold", 32'(bus.o_state), 32'd2);
    chk("ss_rate", 32'(bus.o_rate), 32'd3);
    chk("ss_rv", 32'(bus.o_rate_valid), 32'd1);
    chk("ss_alarms", 32'({bus.o_alarm_hi, bus.o_alarm_lo}), 32'd0);
    cyc();
    chk("ss_hold2_state", 32'(bus.o_state), 32'd2);
    chk("ss_rv_single", 32'(bus.o_rate_valid), 32'd0);
    cyc();
    chk("ss_wait_cls", 32'(bus.o_state), 32'd3);
    bus.i_start = 1'b1;
    cyc();
    bus.i_start = 1'b0;
    chk("ss_start_ignored", 32'(bus.o_state), 32'd3);
    release_cls();
    chk("ss_idle", 32'(bus.o_state), 32'd0);
    chk("ss_idle_count", 32'(bus.o_count), 32'd0);
    chk("ss_rate_kept", 32'(bus.o_rate), 32'd3);
    chk("ss_idle_busy", 32'(bus.o_busy), 32'd0);

    // High alarm: 7 edges before the 2nd tick.
    start_window();
    repeat (5) edge_pulse();
    bus.i_pulse = 1'b1;
    cyc();
    chk("hi_count6", 32'(bus.o_count), 32'd6);
    chk("hi_not_yet", 32'(bus.o_alarm_hi), 32'd0);
    bus.i_pulse = 1'b0;
    cyc();
    chk("hi_set", 32'(bus.o_alarm_hi), 32'd1);
    edge_pulse();
    repeat (3) sec_gap();
    sec();
    chk("hi_rate7", 32'(bus.o_rate), 32'd7);
    chk("hi_in_hold", 32'(bus.o_alarm_hi), 32'd1);
    chk("hi_lo_clear", 32'(bus.o_alarm_lo), 32'd0);
    cyc();
    chk("hi_hold2", 32'(bus.o_alarm_hi), 32'd1);
    cyc();
    chk("hi_wait_cls", 32'(bus.o_alarm_hi), 32'd1);
    release_cls();
    chk("hi_idle_clear", 32'(bus.o_alarm_hi), 32'd0);

    // Low alarm, edge on the final tick counted.
    start_window();
    sec_gap();
    edge_pulse();
    sec_gap();
    sec_gap();
    bus.i_pulse    = 1'b1;
    bus.i_sec_tick = 1'b1;
    cyc();
    bus.i_pulse    = 1'b0;
    bus.i_sec_tick = 1'b0;
    chk("lo_edge_final_rate", 32'(bus.o_rate), 32'd2);
    chk("lo_edge_final_alarm", 32'(bus.o_alarm_lo), 32'd0);
    chk("lo_edge_final_rv", 32'(bus.o_rate_valid), 32'd1);
    cyc();
    cyc();
    release_cls();

    // Same window without the final-tick edge.
    start_window();
    sec_gap();
    edge_pulse();
    sec_gap();
    sec_gap();
    sec();
    chk("lo_rate1", 32'(bus.o_rate), 32'd1);
    chk("lo_alarm", 32'(bus.o_alarm_lo), 32'd1);
    cyc();
    cyc();
    release_cls();
    chk("lo_idle_clear", 32'(bus.o_alarm_lo), 32'd0);

    // Saturation: 17 edges.
    start_window();
    repeat (15) edge_pulse();
    chk("sat_count15", 32'(bus.o_count), 32'd15);
    chk("sat_no_ovf", 32'(bus.o_overflow), 32'd0);
    repeat (2) edge_pulse();
    chk("sat_stuck", 32'(bus.o_count), 32'd15);
    chk("sat_ovf", 32'(bus.o_overflow), 32'd1);
    repeat (3) sec_gap();
    sec();
    chk("sat_rate", 32'(bus.o_rate), 32'd15);
    chk("sat_ovf_hold", 32'(bus.o_overflow), 32'd1);
    cyc();
    cyc();
    release_cls();
    chk("sat_idle_ovf", 32'(bus.o_overflow), 32'd0);

    // Continuous mode: windows of 4 then 2 edges.
    bus.i_cont_mode = 1'b1;
    start_window();
    repeat (4) edge_pulse();
    repeat (3) sec_gap();
    sec();
    chk("cm_rate4", 32'(bus.o_rate), 32'd4);
    chk("cm_rv1", 32'(bus.o_rate_valid), 32'd1);
    cyc();
    chk("cm_rv1_off", 32'(bus.o_rate_valid), 32'd0);
    cyc();
    chk("cm_restart_state", 32'(bus.o_state), 32'd1);
    chk("cm_restart_count", 32'(bus.o_count), 32'd0);
    repeat (2) edge_pulse();
    chk("cm_count2", 32'(bus.o_count), 32'd2);
    repeat (3) sec_gap();
    sec();
    chk("cm_rate2", 32'(bus.o_rate), 32'd2);
    chk("cm_rv2", 32'(bus.o_rate_valid), 32'd1);
    cyc();
    bus.i_stop = 1'b1;
    cyc();
    bus.i_stop = 1'b0;
    chk("cm_stop_hold", 32'(bus.o_state), 32'd0);
    chk("cm_stop_rate", 32'(bus.o_rate), 32'd2);
    bus.i_cont_mode = 1'b0;

    // Abort after the 2nd tick.
    start_window();
    repeat (3) edge_pulse();
    sec_gap();
    sec_gap();
    bus.i_stop = 1'b1;
    cyc();
    bus.i_stop = 1'b0;
    chk("ab_state", 32'(bus.o_state), 32'd0);
    chk("ab_rv", 32'(bus.o_rate_valid), 32'd0);
    chk("ab_rate", 32'(bus.o_rate), 32'd2);
    chk("ab_count", 32'(bus.o_count), 32'd0);

    // Asynchronous reset between clock edges mid-window.
    start_window();
    repeat (6) edge_pulse();
    cyc();
    chk("ar_pre_count", 32'(bus.o_count), 32'd6);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_state", 32'(bus.o_state), 32'd0);
    chk("ar_count", 32'(bus.o_count), 32'd0);
    chk("ar_rate", 32'(bus.o_rate), 32'd0);
    chk("ar_busy", 32'(bus.o_busy), 32'd0);
    chk("ar_alarm_hi", 32'(bus.o_alarm_hi), 32'd0);
    #1;
    rst = 1'b0;
    cyc();
    chk("ar_idle_after", 32'(bus.o_state), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
